// File: rtl/pool_pkg.sv
// rtl/pool_pkg.sv - shared constants, state type and word packing for the pool output buffer
package pool_pkg;

    localparam int BD_DEF = 18;
    localparam int NBANKS = 4;
    localparam int WORD_W = 3 * BD_DEF;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        HANDOFF = 2'd1,
        HOLD    = 2'd2
    } pool_state_e;

    // Channel 0 sits in the low bits so a read unpacks as {c2, c1, c0}.
    function automatic logic [WORD_W-1:0] pack_word(
        input logic [BD_DEF-1:0] c0,
        input logic [BD_DEF-1:0] c1,
        input logic [BD_DEF-1:0] c2
    );
        return {c2, c1, c0};
    endfunction

endpackage

// File: rtl/pool_bank_ram.sv
// rtl/pool_bank_ram.sv - simple dual-port RAM with registered, enabled read port
module pool_bank_ram #(
    parameter int W     = 54,
    parameter int DEPTH = 256,
    parameter int ADW   = 8
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           wr_en,
    input  logic [ADW-1:0] wr_addr,
    input  logic [W-1:0]   wr_data,
    input  logic           rd_en,
    input  logic [ADW-1:0] rd_addr,
    output logic [W-1:0]   rd_data
);

    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rd_data_d;
    logic [W-1:0] rd_data_q;

    // Array contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/pool_out_bank.sv
// rtl/pool_out_bank.sv - four-bank max-pool result buffer; POOL_OUT_RELU_EN clamps negatives on write
module pool_out_bank
    import pool_pkg::*;
#(
    parameter int BD    = BD_DEF,
    parameter int AW    = 11,
    parameter int DEPTH = 256
) (
    input  logic          clk,
    input  logic          RESET,
    input  logic          wren,
    input  logic [1:0]    bram_num,
    input  logic [AW-1:0] wraddr,
    input  logic [BD-1:0] d_c0,
    input  logic [BD-1:0] d_c1,
    input  logic [BD-1:0] d_c2,
    input  logic          next_st,
    input  logic          rden0,
    input  logic          rden1,
    input  logic          rden2,
    input  logic          rden3,
    input  logic [AW-1:0] rd_addr,
    input  logic          rd_done,
    output logic [BD-1:0] q0_c0,
    output logic [BD-1:0] q0_c1,
    output logic [BD-1:0] q0_c2,
    output logic [BD-1:0] q1_c0,
    output logic [BD-1:0] q1_c1,
    output logic [BD-1:0] q1_c2,
    output logic [BD-1:0] q2_c0,
    output logic [BD-1:0] q2_c1,
    output logic [BD-1:0] q2_c2,
    output logic [BD-1:0] q3_c0,
    output logic [BD-1:0] q3_c1,
    output logic [BD-1:0] q3_c2,
    output logic          de_out,
    output logic          ready_out,
    output logic          buf_valid,
    output logic          ovf_err,
    output logic [AW+2:0] wr_count
);

    localparam int W = 3 * BD;
    localparam int RAW = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_LIM = (AW + 1)'(DEPTH);
    localparam logic [AW+2:0] CNT_ONE   = (AW + 3)'(1);

    pool_state_e       state_d, state_q;
    logic [AW+2:0]     wr_count_d, wr_count_q;
    logic              ovf_d, ovf_q;
    logic              de_d, de_q;
    logic [NBANKS-1:0] zero_d, zero_q;

    logic [NBANKS-1:0] rden_v;
    logic [NBANKS-1:0] bank_we;
    logic [NBANKS-1:0] bank_re;
    logic              wr_in_range;
    logic              rd_in_range;
    logic              wr_ok;
    logic              in_hold;
    logic [W-1:0]      wr_word;
    logic [W-1:0]      ram_rd    [NBANKS];
    logic [W-1:0]      bank_word [NBANKS];

    assign rden_v      = {rden3, rden2, rden1, rden0};
    assign wr_in_range = {1'b0, wraddr} < DEPTH_LIM;
    assign rd_in_range = {1'b0, rd_addr} < DEPTH_LIM;
    assign in_hold     = (state_q == HOLD);
    assign wr_ok       = (state_q == FILL) && wren && wr_in_range;

`ifdef POOL_OUT_RELU_EN
    assign wr_word = pack_word(d_c0[BD-1] ? '0 : d_c0,
                               d_c1[BD-1] ? '0 : d_c1,
                               d_c2[BD-1] ? '0 : d_c2);
`else
    assign wr_word = pack_word(d_c0, d_c1, d_c2);
`endif

    always_comb begin
        state_d    = state_q;
        wr_count_d = wr_count_q;
        ovf_d      = ovf_q;
        de_d       = 1'b0;
        zero_d     = zero_q;
        case (state_q)
            FILL: begin
                if (wr_ok) begin
                    wr_count_d = wr_count_q + CNT_ONE;
                end
                if (wren && !wr_in_range) begin
                    ovf_d = 1'b1;
                end
                if (next_st) begin
                    state_d = HANDOFF;
                end
            end
            HANDOFF: begin
                if (wren) begin
                    ovf_d = 1'b1;
                end
                state_d = HOLD;
            end
            HOLD: begin
                if (wren) begin
                    ovf_d = 1'b1;
                end
                if (|rden_v) begin
                    de_d = 1'b1;
                    if (!rd_in_range) begin
                        ovf_d = 1'b1;
                    end
                end
                // An out-of-range read zeroes that bank until its next good read.
                for (int n = 0; n < NBANKS; n++) begin
                    if (rden_v[n]) begin
                        zero_d[n] = !rd_in_range;
                    end
                end
                if (rd_done) begin
                    state_d    = FILL;
                    wr_count_d = '0;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!RESET) begin
            state_q    <= FILL;
            wr_count_q <= '0;
            ovf_q      <= 1'b0;
            de_q       <= 1'b0;
            zero_q     <= '0;
        end else begin
            state_q    <= state_d;
            wr_count_q <= wr_count_d;
            ovf_q      <= ovf_d;
            de_q       <= de_d;
            zero_q     <= zero_d;
        end
    end

    for (genvar n = 0; n < NBANKS; n++) begin : g_bank
        assign bank_we[n] = wr_ok && (bram_num == 2'(n));
        assign bank_re[n] = in_hold && rden_v[n] && rd_in_range;

        pool_bank_ram #(
            .W     (W),
            .DEPTH (DEPTH),
            .ADW   (RAW)
        ) u_ram (
            .clk     (clk),
            .resetn  (RESET),
            .wr_en   (bank_we[n]),
            .wr_addr (wraddr[RAW-1:0]),
            .wr_data (wr_word),
            .rd_en   (bank_re[n]),
            .rd_addr (rd_addr[RAW-1:0]),
            .rd_data (ram_rd[n])
        );

        assign bank_word[n] = zero_q[n] ? '0 : ram_rd[n];
    end

    assign {q0_c2, q0_c1, q0_c0} = bank_word[0];
    assign {q1_c2, q1_c1, q1_c0} = bank_word[1];
    assign {q2_c2, q2_c1, q2_c0} = bank_word[2];
    assign {q3_c2, q3_c1, q3_c0} = bank_word[3];

    assign ready_out = (state_q == HANDOFF);
    assign buf_valid = (state_q != FILL);
    assign de_out    = de_q;
    assign ovf_err   = ovf_q;
    assign wr_count  = wr_count_q;

endmodule
